// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, FSM states
// and the flag bundle layout used by alu_mc and its consumers.
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_NOR   = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SLTU  = 4'd6;
   localparam logic [3:0] ALU_PASSB = 4'd7;
   localparam logic [3:0] ALU_SLL   = 4'd8;
   localparam logic [3:0] ALU_SRL   = 4'd9;
   localparam logic [3:0] ALU_SRA   = 4'd10;
   localparam logic [3:0] ALU_SLT   = 4'd11;
   localparam logic [3:0] ALU_MUL   = 4'd12;
   localparam logic [3:0] ALU_MULHU = 4'd13;

   // DONE is folded into IDLE: both accept the next operation identically.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// product carries the final value combinationally during the done cycle.
module alu_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;

   assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign busy     = busy_q;
   assign done     = busy_q && (cnt_q == CW'(1));
   assign product  = acc_next;

   // NOTE: sequential state is assigned with <= so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= CW'(WIDTH);
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith/shift
// ops complete on the accept edge, multiplies run WIDTH cycles in alu_mul_seq.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       func,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero_flag,
   output logic             neg_flag,
   output logic             carry_flag,
   output logic             ovf_flag
);

   localparam int SHW = $clog2(WIDTH);

   state_t             state;
   logic [WIDTH-1:0]   out_q;
   flags_t             flags_q;
   logic               out_valid_q;
   logic               mul_hi_q;

   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_ovf;
   logic               accept;
   logic               is_mul;

   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH-1:0]   mul_res;

   function automatic flags_t make_flags(input logic [WIDTH-1:0] v,
                                         input logic c, input logic o);
      flags_t f;
      f.zero  = (v == '0);
      f.neg   = v[WIDTH-1];
      f.carry = c;
      f.ovf   = o;
      return f;
   endfunction

   assign shamt    = b[SHW-1:0];
   assign add_full = {1'b0, a} + {1'b0, b};
   // Top bit of the extended difference is the unsigned borrow (a < b).
   assign sub_full = {1'b0, a} - {1'b0, b};

   assign is_mul   = (func == ALU_MUL) || (func == ALU_MULHU);
   assign in_ready = (state == S_IDLE) && !mul_busy && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // NOTE: every always_comb output gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (func)
         ALU_ADD: begin
            alu_res   = add_full[WIDTH-1:0];
            alu_carry = add_full[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res   = sub_full[WIDTH-1:0];
            alu_carry = sub_full[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND:   alu_res = a & b;
         ALU_OR:    alu_res = a | b;
         ALU_NOR:   alu_res = ~(a | b);
         ALU_XOR:   alu_res = a ^ b;
         ALU_SLTU:  alu_res[0] = sub_full[WIDTH];
         ALU_PASSB: alu_res = b;
         ALU_SLL:   alu_res = a << shamt;
         ALU_SRL:   alu_res = a >> shamt;
         ALU_SRA:   alu_res = $unsigned($signed(a) >>> shamt);
         ALU_SLT:   alu_res[0] = ($signed(a) < $signed(b));
         default:   alu_res = '0;
      endcase
   end

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign mul_res = mul_hi_q ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         out_q       <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         mul_hi_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept && is_mul) begin
                  state       <= S_MUL;
                  mul_hi_q    <= (func == ALU_MULHU);
                  out_valid_q <= 1'b0;
               end else if (accept) begin
                  out_q       <= alu_res;
                  flags_q     <= make_flags(alu_res, alu_carry, alu_ovf);
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            S_MUL: begin
               if (mul_done) begin
                  out_q       <= mul_res;
                  flags_q     <= make_flags(mul_res, 1'b0, 1'b0);
                  out_valid_q <= 1'b1;
                  state       <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign zero_flag  = flags_q.zero;
   assign neg_flag   = flags_q.neg;
   assign carry_flag = flags_q.carry;
   assign ovf_flag   = flags_q.ovf;

endmodule
